// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// fetch FSM state encoding and instruction field bit positions.
package instr_fetch_pkg;

  // Opcodes seen by the downstream control decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Instruction field bit positions.
  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned TARGET_HI = 25;
  localparam int unsigned TARGET_LO = 0;
  localparam int unsigned IMM_HI    = 15;
  localparam int unsigned IMM_LO    = 0;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StValid = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next-PC selection for the fetch stage: jump, taken branch or sequential.
// Purely combinational; the caller decides when the result is used.
module instr_fetch_next_pc
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]    pc_plus4,
  input  logic [TARGET_HI:0]   instr_low,
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 zero,
  output logic [ADDR_W-1:0]    npc
);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] branch_target;

  // Target computation; additions wrap modulo 2^ADDR_W.
  always_comb begin
    jump_target   = {pc_plus4[ADDR_W-1:28], instr_low[TARGET_HI:TARGET_LO], 2'b00};
    branch_off    = {{(ADDR_W-18){instr_low[IMM_HI]}}, instr_low[IMM_HI:IMM_LO], 2'b00};
    branch_target = pc_plus4 + branch_off;
  end

  // Priority mux: jump beats a taken branch, which beats sequential.
  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = jump_target;
    end else if (branch && zero) begin
      npc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/ack handshake and presents it to control/datapath via valid/ready.
// Optional build macro IFETCH_PERF_EN adds a saturating wait_cycles counter.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       wait_cycles,
`endif
  input  logic              Jump,
  input  logic              Branch,
  input  logic              Zero
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] npc;

  instr_fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_plus4  (pc_plus4),
    .instr_low (ir_q[TARGET_HI:0]),
    .jump      (Jump),
    .branch    (Branch),
    .zero      (Zero),
    .npc       (npc)
  );

  // State, PC and instruction register; reset abandons any outstanding fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; acks outside FETCH and jump/branch outside accept are ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        if (instr_ready) begin
          pc_d    = npc;
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from registered state so they drop on async reset.
  always_comb begin
    imem_req    = (state_q == StFetch);
    instr_valid = (state_q == StValid);
    imem_addr   = pc_q;
    pc_out      = pc_q;
    pc_plus4    = pc_q + ADDR_W'(4);
    instr       = ir_q;
    opcode      = ir_q[OPCODE_HI:OPCODE_LO];
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] wait_q;
  logic        wait_inc;

  assign wait_inc = ((state_q == StFetch) && !imem_ack) ||
                    ((state_q == StValid) && !instr_ready);

  // Stall counter: memory wait states plus datapath backpressure, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (wait_inc && (wait_q != 32'hFFFF_FFFF)) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  assign wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        Jump, Branch, Zero;
`ifdef IFETCH_PERF_EN
  logic [31:0] wait_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
`ifdef IFETCH_PERF_EN
    .wait_cycles (wait_cycles),
`endif
    .Jump        (Jump),
    .Branch      (Branch),
    .Zero        (Zero)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        jmp;
    logic        br;
    logic        zr;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_wait;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic jmp, input logic br, input logic zr,
                              input logic exp_req, input logic [31:0] exp_pc,
                              input logic exp_valid, input logic [31:0] exp_instr,
                              input logic [31:0] exp_wait);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.jmp = jmp; v.br = br; v.zr = zr;
    v.exp_req = exp_req; v.exp_pc = exp_pc; v.exp_valid = exp_valid;
    v.exp_instr = exp_instr; v.exp_wait = exp_wait;
    return v;
  endfunction

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic jmp, input logic br, input logic zr);
    imem_ack = ack; imem_rdata = rdata; instr_ready = ready;
    Jump = jmp; Branch = br; Zero = zr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_op;

    // Each row: inputs before the edge, outputs expected after it.
    vecs[0]  = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'h0,         0, 32'h0,         0);
    vecs[1]  = mk(1, 32'h8C08_0004, 0, 0, 0, 0, 0, 32'h0,         1, 32'h8C08_0004, 0);
    vecs[2]  = mk(0, 32'h0,         1, 0, 0, 0, 1, 32'h4,         0, 32'h8C08_0004, 0);
    vecs[3]  = mk(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h4,         0, 32'h8C08_0004, 1);
    vecs[4]  = mk(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h4,         0, 32'h8C08_0004, 2);
    vecs[5]  = mk(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'h4,         0, 32'h8C08_0004, 3);
    vecs[6]  = mk(1, 32'h0800_0004, 0, 0, 0, 0, 0, 32'h4,         1, 32'h0800_0004, 3);
    vecs[7]  = mk(1, 32'hDEAD_BEEF, 0, 1, 1, 1, 0, 32'h4,         1, 32'h0800_0004, 4);
    vecs[8]  = mk(1, 32'hDEAD_BEEF, 0, 1, 1, 1, 0, 32'h4,         1, 32'h0800_0004, 5);
    vecs[9]  = mk(0, 32'h0,         1, 1, 0, 0, 1, 32'h10,        0, 32'h0800_0004, 5);
    vecs[10] = mk(1, 32'h1109_FFFC, 0, 0, 0, 0, 0, 32'h10,        1, 32'h1109_FFFC, 5);
    vecs[11] = mk(0, 32'h0,         1, 0, 1, 1, 1, 32'h4,         0, 32'h1109_FFFC, 5);
    vecs[12] = mk(1, 32'h0800_0004, 0, 0, 0, 0, 0, 32'h4,         1, 32'h0800_0004, 5);
    vecs[13] = mk(0, 32'h0,         1, 1, 0, 0, 1, 32'h10,        0, 32'h0800_0004, 5);
    vecs[14] = mk(1, 32'h1109_FFFC, 0, 0, 0, 0, 0, 32'h10,        1, 32'h1109_FFFC, 5);
    vecs[15] = mk(0, 32'h0,         1, 0, 1, 0, 1, 32'h14,        0, 32'h1109_FFFC, 5);
    vecs[16] = mk(1, 32'h0800_0008, 0, 0, 0, 0, 0, 32'h14,        1, 32'h0800_0008, 5);
    vecs[17] = mk(0, 32'h0,         1, 1, 0, 0, 1, 32'h20,        0, 32'h0800_0008, 5);
    vecs[18] = mk(1, 32'h0800_0040, 0, 0, 0, 0, 0, 32'h20,        1, 32'h0800_0040, 5);
    vecs[19] = mk(0, 32'h0,         1, 1, 1, 1, 1, 32'h100,       0, 32'h0800_0040, 5);
    vecs[20] = mk(1, 32'h1000_FFBE, 0, 0, 0, 0, 0, 32'h100,       1, 32'h1000_FFBE, 5);
    vecs[21] = mk(0, 32'h0,         1, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h1000_FFBE, 5);
    vecs[22] = mk(1, 32'h0,         0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h0,         5);
    vecs[23] = mk(0, 32'h0,         1, 0, 0, 0, 1, 32'h0,         0, 32'h0,         5);

    // Reset state.
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_req",      {31'b0, imem_req},    32'h0);
    chk("rst_valid",    {31'b0, instr_valid}, 32'h0);
    chk("rst_pc_out",   pc_out,               32'h0);
    chk("rst_pc_plus4", pc_plus4,             32'h4);
    chk("rst_instr",    instr,                32'h0);
    chk("rst_opcode",   {26'b0, opcode},      32'h0);
`ifdef IFETCH_PERF_EN
    chk("rst_wait",     wait_cycles,          32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].jmp, vecs[i].br, vecs[i].zr);
      step();
      exp_op = vecs[i].exp_instr;
      chk($sformatf("v%0d_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_valid", i),  {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_addr", i),   imem_addr,            vecs[i].exp_pc);
      chk($sformatf("v%0d_pc_out", i), pc_out,               vecs[i].exp_pc);
      chk($sformatf("v%0d_pc4", i),    pc_plus4,             vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_instr", i),  instr,                vecs[i].exp_instr);
      chk($sformatf("v%0d_opcode", i), {26'b0, opcode},      {26'b0, exp_op[31:26]});
`ifdef IFETCH_PERF_EN
      chk($sformatf("v%0d_wait", i),   wait_cycles,          vecs[i].exp_wait);
`endif
    end

    // Reset in the middle of a FETCH at 0x14.
    drive(1, 32'h0800_0005, 0, 0, 0, 0);
    step();
    chk("mr_valid_pc0", pc_out, 32'h0);
    drive(0, 32'h0, 1, 1, 0, 0);
    step();
    chk("mr_addr14", imem_addr, 32'h14);
    drive(0, 32'h0, 0, 0, 0, 0);
    step();
    chk("mr_req_before", {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_req_drop",  {31'b0, imem_req},    32'h0);
    chk("mr_valid",     {31'b0, instr_valid}, 32'h0);
    chk("mr_pc_out",    pc_out,               32'h0);
    chk("mr_instr",     instr,                32'h0);
    // Stray ack while reset is held.
    drive(1, 32'h1234_5678, 0, 0, 0, 0);
    step();
    chk("mr_stray_valid", {31'b0, instr_valid}, 32'h0);
    chk("mr_stray_instr", instr,                32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mr_restart_req",   {31'b0, imem_req},    32'h1);
    chk("mr_restart_addr",  imem_addr,            32'h0);
    chk("mr_restart_valid", {31'b0, instr_valid}, 32'h0);
    chk("mr_restart_instr", instr,                32'h0);
    drive(0, 32'h0, 0, 0, 0, 0);
    step();
    chk("mr_wait_req", {31'b0, imem_req}, 32'h1);
    drive(1, 32'h8C08_0004, 0, 0, 0, 0);
    step();
    chk("mr_refetch_valid", {31'b0, instr_valid}, 32'h1);
    chk("mr_refetch_instr", instr,                32'h8C08_0004);
    chk("mr_refetch_pc",    pc_out,               32'h0);
`ifdef IFETCH_PERF_EN
    chk("mr_wait_cnt",      wait_cycles,          32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
